mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequencer and arbiter for the shared 16-bit MAR/MDR memory path.
- Arbitrates between an instruction-fetch requester and a data load/store requester.
- Drives MAR/MDR load strobes and the address/data muxes into them.
- Generates active-low SRAM OE/WE with a programmable wait-state count, and returns read data plus a one-cycle acknowledge to the granted requester.

Parameters:
- N, 16: address/data width; matches MAR/MDR width.
- WAIT, 2: SRAM access cycles with OE_N/WE_N asserted; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on rising Clk.
- fetch_req  in  1  fetch request; level, held until fetch_ack.
- fetch_addr  in  N  fetch address.
- data_req  in  1  data request; level, held until data_ack.
- data_we  in  1  1 = store, 0 = load; sampled at grant.
- data_addr  in  N  data address.
- data_wdata  in  N  store data.
- Data_from_SRAM  in  N  SRAM read bus.
- LD_MAR  out  1  MAR load strobe.
- MAR_DIN  out  N  address into MAR.
- LD_MDR  out  1  MDR load strobe.
- MDR_DIN  out  N  data into MDR: store data, or SRAM read data.
- OE_N  out  1  SRAM output enable, active low.
- WE_N  out  1  SRAM write enable, active low.
- fetch_ack  out  1  one-cycle completion pulse to fetch requester.
- data_ack  out  1  one-cycle completion pulse to data requester.
- rdata  out  N  read data; valid with the ack, held until the next read capture.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (Reset = 0 at a rising edge) from any state, including mid-access:
  - state = IDLE, wait counter = 0, last_grant = data (so fetch wins the first tie).
  - LD_MAR = 0, LD_MDR = 0, OE_N = 1, WE_N = 1, both acks = 0, busy = 0, rdata = 0, MAR_DIN = 0, MDR_DIN = 0.
  - An aborted transaction produces no ack.
- States: IDLE, LOAD, ACCESS, CAPTURE, DONE.
- IDLE:
  - If any request is high, grant and latch the requester id, op (fetch always reads), address and wdata, then go to LOAD.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single request: it is granted.
  - Both requests high: grant the requester not granted last (round-robin).
  - last_grant updates at grant.
- LOAD (1 cycle):
  - LD_MAR = 1, MAR_DIN = latched address.
  - On a store, also LD_MDR = 1 and MDR_DIN = latched wdata.
  - Next state: ACCESS, counter = 0.
- ACCESS (WAIT cycles):
  - Read: OE_N = 0. Write: WE_N = 0.
  - Counter increments each cycle; when counter = WAIT-1, leave ACCESS.
  - Read goes to CAPTURE; write goes to DONE.
- CAPTURE (reads only, 1 cycle):
  - OE_N stays 0.
  - LD_MDR = 1, MDR_DIN = Data_from_SRAM, and rdata <= Data_from_SRAM.
  - Next state: DONE.
- DONE (1 cycle):
  - Ack of the latched requester = 1; OE_N = WE_N = 1.
  - Next state: IDLE.
- Latency, with requests sampled high in IDLE at edge t:
  - LOAD at t+1; ACCESS at t+2 .. t+1+WAIT.
  - Read ack at t+3+WAIT.
  - Write ack at t+2+WAIT.
- Requester rules:
  - A requester must drop its request in the cycle after its ack.
  - A request still high on return to IDLE starts a new transaction.
  - Request drop or change mid-transaction is ignored; latched values are used.
- Outputs are combinational decodes of registered state only; no combinational path from inputs to outputs.
- OE_N and WE_N are never low in the same cycle.
- Strobes and muxes not asserted in a given state: strobes = 0, muxes hold 0.

Test Plan:
- Reset = 0 for 2 cycles with fetch_req = 1 → all outputs at reset values. Release → grant fetch; LD_MAR pulse with MAR_DIN = fetch_addr.
- Fetch read, WAIT = 2, fetch_addr = 16'h3000, SRAM returns 16'h1234 → OE_N low for 3 cycles (ACCESS ×2 + CAPTURE); fetch_ack pulses at t+5 with rdata = 16'h1234.
- Store, data_addr = 16'h4000, data_wdata = 16'hBEEF → LD_MAR and LD_MDR in the same cycle with MDR_DIN = 16'hBEEF; WE_N low exactly 2 cycles; data_ack at t+4; OE_N stays 1 throughout.
- Both requests held continuously → grants alternate fetch, data, fetch, data; each ack goes only to its owner; busy low exactly one cycle between transactions.
- Reset asserted during ACCESS of a read → next cycle IDLE, OE_N = 1, no ack issued, rdata unchanged at 0.
- WAIT = 1 and WAIT = 15 builds → OE_N low for WAIT+1 cycles on reads and WE_N low for WAIT cycles on writes; latency matches the formula.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter for the shared MAR/MDR memory path: round-robin grant between
// fetch and data requesters, SRAM OE_N/WE_N timing with WAIT access cycles, one-cycle acks.
module mem_access_ctrl #(
  parameter int N    = 16,
  parameter int WAIT = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         fetch_req,
  input  logic [N-1:0] fetch_addr,
  input  logic         data_req,
  input  logic         data_we,
  input  logic [N-1:0] data_addr,
  input  logic [N-1:0] data_wdata,
  input  logic [N-1:0] Data_from_SRAM,
  output logic         LD_MAR,
  output logic [N-1:0] MAR_DIN,
  output logic         LD_MDR,
  output logic [N-1:0] MDR_DIN,
  output logic         OE_N,
  output logic         WE_N,
  output logic         fetch_ack,
  output logic         data_ack,
  output logic [N-1:0] rdata,
  output logic         busy,
  output logic [2:0]   state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         last_q, last_d;   // 1 = data requester was granted last
  logic         id_q, id_d;       // 1 = current owner is the data requester
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         gnt_data;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state; request inputs are only looked at in IDLE, so later changes are ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    gnt_data = data_req && (!fetch_req || !last_q);
    case (state_q)
      S_IDLE: begin
        if (fetch_req || data_req) begin
          id_d    = gnt_data;
          last_d  = gnt_data;
          we_d    = gnt_data && data_we;
          addr_d  = gnt_data ? data_addr : fetch_addr;
          wdata_d = data_wdata;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == 4'(WAIT - 1)) begin
          state_d = we_q ? S_DONE : S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        rdata_d = Data_from_SRAM;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    LD_MAR    = 1'b0;
    MAR_DIN   = '0;
    LD_MDR    = 1'b0;
    MDR_DIN   = '0;
    OE_N      = 1'b1;
    WE_N      = 1'b1;
    fetch_ack = 1'b0;
    data_ack  = 1'b0;
    case (state_q)
      S_LOAD: begin
        LD_MAR  = 1'b1;
        MAR_DIN = addr_q;
        if (we_q) begin
          LD_MDR  = 1'b1;
          MDR_DIN = wdata_q;
        end
      end
      S_ACCESS: begin
        OE_N = we_q;
        WE_N = !we_q;
      end
      S_CAPTURE: begin
        OE_N    = 1'b0;
        LD_MDR  = 1'b1;
        MDR_DIN = Data_from_SRAM;
      end
      S_DONE: begin
        fetch_ack = !id_q;
        data_ack  = id_q;
      end
      default: ;
    endcase
  end

  assign rdata   = rdata_q;
  assign busy    = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (WAIT = 2, 1, 15) on a shared reset,
// table-driven single transactions plus reset-abort and round-robin sequences.
module tb_mem_access_ctrl;

  logic                 clk;
  logic                 rst_n;
  logic [2:0]           fetch_req, data_req, data_we;
  logic [2:0][15:0]     fetch_addr, data_addr, data_wdata, sram;
  logic [2:0]           ld_mar, ld_mdr, oe_n, we_n, fetch_ack, data_ack, busy;
  logic [2:0][15:0]     mar_din, mdr_din, rdata;
  logic [2:0][2:0]      state;

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(.N(16), .WAIT(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .Clk(clk), .Reset(rst_n),
      .fetch_req(fetch_req[g]), .fetch_addr(fetch_addr[g]),
      .data_req(data_req[g]), .data_we(data_we[g]),
      .data_addr(data_addr[g]), .data_wdata(data_wdata[g]),
      .Data_from_SRAM(sram[g]),
      .LD_MAR(ld_mar[g]), .MAR_DIN(mar_din[g]),
      .LD_MDR(ld_mdr[g]), .MDR_DIN(mdr_din[g]),
      .OE_N(oe_n[g]), .WE_N(we_n[g]),
      .fetch_ack(fetch_ack[g]), .data_ack(data_ack[g]),
      .rdata(rdata[g]), .busy(busy[g]), .state_o(state[g])
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          d;
    bit          is_data;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sram;
    int          lat;
    int          oe_cnt;
    int          we_cnt;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // One transaction on instance v.d; inputs are scrambled after grant to prove latching.
  task automatic run_vec(input vec_t v, input int idx);
    int d = v.d;
    int n = 0;
    int ack_n = -1;
    int oe = 0, wel = 0, both = 0, wrong = 0;
    int mar_cnt = 0, mar_n = -1, mdr_cnt = 0, mdr_n = -1;
    logic [15:0] mar_v = '0, mdr_v = '0, rd_v = '0;
    @(negedge clk);
    sram[d] = v.sram;
    if (v.is_data) begin
      data_we[d] = v.we; data_addr[d] = v.addr; data_wdata[d] = v.wdata; data_req[d] = 1'b1;
    end else begin
      fetch_addr[d] = v.addr; data_wdata[d] = v.wdata; fetch_req[d] = 1'b1;
    end
    while (ack_n < 0 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!oe_n[d]) oe++;
      if (!we_n[d]) wel++;
      if (!oe_n[d] && !we_n[d]) both++;
      if (!busy[d]) wrong++;
      if (ld_mar[d]) begin mar_cnt++; mar_n = n; mar_v = mar_din[d]; end
      if (ld_mdr[d]) begin mdr_cnt++; mdr_n = n; mdr_v = mdr_din[d]; end
      if (v.is_data ? fetch_ack[d] : data_ack[d]) wrong++;
      if (v.is_data ? data_ack[d] : fetch_ack[d]) begin
        ack_n = n; rd_v = rdata[d];
        fetch_req[d] = 1'b0; data_req[d] = 1'b0;
      end
      if (n == 1) begin
        fetch_addr[d] = ~v.addr; data_addr[d] = ~v.addr;
        data_wdata[d] = ~v.wdata; data_we[d] = ~v.we;
      end
    end
    fetch_req[d] = 1'b0; data_req[d] = 1'b0;
    check($sformatf("v%0d ack_latency", idx), ack_n, v.lat);
    check($sformatf("v%0d oe_low_cycles", idx), oe, v.oe_cnt);
    check($sformatf("v%0d we_low_cycles", idx), wel, v.we_cnt);
    check($sformatf("v%0d oe_we_overlap", idx), both, 0);
    check($sformatf("v%0d wrong_ack_or_idle", idx), wrong, 0);
    check($sformatf("v%0d ld_mar_count", idx), mar_cnt, 1);
    check($sformatf("v%0d ld_mar_cycle", idx), mar_n, 1);
    check($sformatf("v%0d mar_din", idx), mar_v, v.addr);
    check($sformatf("v%0d ld_mdr_count", idx), mdr_cnt, 1);
    check($sformatf("v%0d ld_mdr_cycle", idx), mdr_n, v.we ? 1 : v.lat - 1);
    check($sformatf("v%0d mdr_din", idx), mdr_v, v.we ? v.wdata : v.sram);
    check($sformatf("v%0d rdata", idx), rd_v, v.exp_rdata);
  endtask

  initial begin
    int acks, k, busy_low, both_ack;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_req[i] = 1'b0; data_req[i] = 1'b0; data_we[i] = 1'b0;
      fetch_addr[i] = '0; data_addr[i] = '0; data_wdata[i] = '0; sram[i] = 16'hDEAD;
    end
    //               d  data we addr      wdata     sram      lat oe  we  rdata
    vecs[0] = '{0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 5,  3,  0,  16'h1234};
    vecs[1] = '{0, 1'b1, 1'b1, 16'h4000, 16'hBEEF, 16'h9999, 4,  0,  2,  16'h1234};
    vecs[2] = '{0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 5,  3,  0,  16'h0000};
    vecs[3] = '{0, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'hA5A5, 5,  3,  0,  16'hA5A5};
    vecs[4] = '{1, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h5555, 4,  2,  0,  16'h5555};
    vecs[5] = '{1, 1'b1, 1'b1, 16'h1234, 16'h0F0F, 16'h0000, 3,  0,  1,  16'h5555};
    vecs[6] = '{2, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'hCAFE, 18, 16, 0,  16'hCAFE};
    vecs[7] = '{2, 1'b1, 1'b1, 16'h7FFF, 16'h1111, 16'h0000, 17, 0,  15, 16'hCAFE};

    // Reset held two cycles with a fetch pending, then release and abort mid-ACCESS.
    fetch_req[0] = 1'b1; fetch_addr[0] = 16'h0ABC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst state", state[0], 0);
    check("rst ld_mar", ld_mar[0], 0);
    check("rst ld_mdr", ld_mdr[0], 0);
    check("rst oe_n", oe_n[0], 1);
    check("rst we_n", we_n[0], 1);
    check("rst acks", {fetch_ack[0], data_ack[0]}, 0);
    check("rst busy", busy, 0);
    check("rst rdata", rdata[0], 0);
    check("rst mar_din", mar_din[0], 0);
    check("rst mdr_din", mdr_din[0], 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("grant ld_mar", ld_mar[0], 1);
    check("grant mar_din", mar_din[0], 16'h0ABC);
    @(posedge clk); @(negedge clk);
    check("access oe_n", oe_n[0], 0);
    rst_n = 1'b0; fetch_req[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort state", state[0], 0);
    check("abort oe_n", oe_n[0], 1);
    check("abort busy", busy[0], 0);
    check("abort rdata", rdata[0], 0);
    rst_n = 1'b1;
    acks = 0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (fetch_ack[0] || data_ack[0]) acks++;
    end
    check("abort no_ack", acks, 0);
    check("abort rdata_after", rdata[0], 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Round robin on instance 0: last grant was data, so fetch goes first.
    @(negedge clk);
    fetch_addr[0] = 16'h1111; data_addr[0] = 16'h2222; data_we[0] = 1'b0; sram[0] = 16'h7777;
    fetch_req[0] = 1'b1; data_req[0] = 1'b1;
    k = 0; busy_low = 0; both_ack = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (fetch_ack[0] && data_ack[0]) both_ack++;
      if (!busy[0]) busy_low++;
      if (ld_mar[0]) check($sformatf("rr%0d mar_din", k), mar_din[0], (k % 2) ? 16'h2222 : 16'h1111);
      if (fetch_ack[0] || data_ack[0]) begin
        check($sformatf("rr%0d owner", k), data_ack[0], k % 2);
        check($sformatf("rr%0d rdata", k), rdata[0], 16'h7777);
        if (k > 0) check($sformatf("rr%0d busy_gap", k), busy_low, 1);
        busy_low = 0;
        k++;
        if (k == 4) begin fetch_req[0] = 1'b0; data_req[0] = 1'b0; end
      end
    end
    fetch_req[0] = 1'b0; data_req[0] = 1'b0;
    check("rr grants", k, 4);
    check("rr double_ack", both_ack, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rr idle", busy[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
